// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer that shares one external combinational ALU between two requesters.
// Optional ALU_OPCHECK_EN: F=3'b011 is rejected with an error response and skips execution.
module alu_rr_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FW    = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [FW-1:0]    req_f0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [FW-1:0]    req_f1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FW-1:0]    alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_of,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_y,
  output logic             resp_of,
  output logic             resp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [FW-1:0]    alu_f_q, alu_f_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_y_q, resp_y_d;
  logic             resp_of_q, resp_of_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             grant;
  logic             any_valid;
  logic             illegal;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [FW-1:0]    sel_f;

`ifdef ALU_OPCHECK_EN
  localparam logic [FW-1:0] IllegalF = FW'(3);
  logic resp_err_q, resp_err_d;
`endif

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    any_valid = |req_valid;
    case (req_valid)
      2'b11:   grant = ~last_grant_q;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
    sel_a = grant ? req_a1 : req_a0;
    sel_b = grant ? req_b1 : req_b0;
    sel_f = grant ? req_f1 : req_f0;
`ifdef ALU_OPCHECK_EN
    illegal = (sel_f == IllegalF);
`else
    illegal = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_f_d      = alu_f_q;
    resp_id_d    = resp_id_q;
    resp_y_d     = resp_y_q;
    resp_of_d    = resp_of_q;
    op_count_d   = op_count_q;
`ifdef ALU_OPCHECK_EN
    resp_err_d   = resp_err_q;
`endif
    req_ready    = 2'b00;
    resp_valid   = 1'b0;

    case (state_q)
      StIdle: begin
        req_ready[grant] = any_valid;
        if (any_valid) begin
          last_grant_d = grant;
          id_d         = grant;
          if (illegal) begin
            // Rejected op: the ALU operand registers are left untouched.
            resp_id_d  = grant;
            resp_y_d   = '0;
            resp_of_d  = 1'b0;
`ifdef ALU_OPCHECK_EN
            resp_err_d = 1'b1;
`endif
            state_d    = StResp;
          end else begin
            alu_a_d = sel_a;
            alu_b_d = sel_b;
            alu_f_d = sel_f;
            state_d = StExec;
          end
        end
      end

      StExec: begin
        resp_y_d   = alu_y;
        resp_of_d  = alu_of;
        resp_id_d  = id_q;
`ifdef ALU_OPCHECK_EN
        resp_err_d = 1'b0;
`endif
        state_d    = StResp;
      end

      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_f_q      <= '0;
      resp_id_q    <= 1'b0;
      resp_y_q     <= '0;
      resp_of_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_f_q      <= alu_f_d;
      resp_id_q    <= resp_id_d;
      resp_y_q     <= resp_y_d;
      resp_of_q    <= resp_of_d;
      op_count_q   <= op_count_d;
    end
  end

`ifdef ALU_OPCHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= resp_err_d;
    end
  end

  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_f    = alu_f_q;
  assign resp_id  = resp_id_q;
  assign resp_y   = resp_y_q;
  assign resp_of  = resp_of_q;
  assign op_count = op_count_q;

endmodule
